axis_prng_multi: RTL and testbench
==================================

Name: axis_prng_multi

Overview:
- Parametrised successor to the single-lane 32-bit AXI-Stream random generator.
- Produces LANES independent 32-bit xorshift32 streams packed into one AXI-Stream word.
- Seeds every lane from one 32-bit seed using the MT19937 initialisation recurrence.
- Supports an optional fixed-length burst mode with tlast, so benches and DMA consumers can capture N words and stop cleanly.

Parameters:
- LANES, 4, number of 32-bit generator lanes (1..16); tdata width = 32*LANES.
- AUTO_SEED, 1, if 1, seed with DEFAULT_SEED automatically after reset release.
- DEFAULT_SEED, 5489, seed used by auto-seeding.
- CNT_W, 16, width of burst_len and of the internal word counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- seed_val  in  32  seed, captured while seed_start is high
- seed_start  in  1  level request: (re)seed from seed_val
- burst_len  in  CNT_W  words per burst, captured with the seed; 0 = free-run
- output_axis_tdata  out  32*LANES  lane i occupies bits [32*i+31:32*i]
- output_axis_tvalid  out  1  AXI-Stream valid
- output_axis_tready  in  1  AXI-Stream ready
- output_axis_tlast  out  1  high on the last word of a burst
- busy  out  1  high while seeding or priming

Behaviour:
- Reset values: all outputs 0 (tdata, tvalid, tlast, busy); lane states 0; FSM = IDLE; counter 0. Reset dominates seed_start.
- FSM states are IDLE, SEED, PRIME, RUN, DONE.
- IDLE:
  - On leaving reset with AUTO_SEED=1 and seed_start low: load DEFAULT_SEED, burst_len := 0, go to SEED.
  - Otherwise wait for seed_start.
- seed_start high in any state:
  - Capture seed_val and burst_len.
  - Force tvalid=0 and tlast=0, clear the counter, set the lane index to 0, enter SEED.
  - Stay there while seed_start is high. Seeding begins in the cycle after seed_start falls.
  - Aborting a stalled transfer (tvalid & !tready) this way is the only permitted AXI-S stability exception.
- SEED, one lane per cycle, LANES cycles:
  - s[0] = seed.
  - s[i] = 1812433253*(s[i-1] ^ (s[i-1]>>30)) + i, mod 2^32.
  - Any computed s[i]==0 is stored as 32'h1 (xorshift forbids zero).
- PRIME, 1 cycle: tdata lane i := xs(s[i]), and s[i] := that value.
  - xs(x): x ^= x<<13; x ^= x>>17; x ^= x<<5 (all 32-bit).
- Timing:
  - busy=1 from the first SEED cycle through PRIME.
  - tvalid rises exactly LANES+1 cycles after seed_start is first sampled low.
- RUN:
  - tvalid=1. tdata and tlast hold while !tready.
  - On tvalid & tready, every lane advances by one xs step and the next tdata is valid in the following cycle with no bubble (1 word/cycle at full tready).
- Burst mode (burst_len=N>0):
  - The counter increments per accepted word; tlast=1 on word N.
  - Acceptance of word N leads to DONE: tvalid=0, busy=0.
  - DONE is left only via seed_start or rst.
  - N=1: the first word carries tlast.
  - The counter never wraps in burst mode.
- Free-run (burst_len=0): tlast stays 0; the counter wraps silently at 2^CNT_W.
- tready is ignored outside RUN. tvalid never depends combinationally on tready.

Decomposition:
- Package prng_pkg holds:
  - FSM state enum;
  - MT_INIT_MULT = 32'd1812433253 and MT_INIT_SHIFT = 30;
  - xorshift shift constants 13/17/5;
  - the pure function xs32().
- One sub-module, xorshift32_lane: a 32-bit state register with load (seed value) and advance (xs step) enables. It is instantiated LANES times by a generate loop.
- Top-level logic holds the FSM, the seeding recurrence (one shared multiplier, sequential across lanes), the counter and the tlast logic.

Test Plan:
- Reset seed: LANES=4, seed_val=1, seed_start pulsed 1 cycle → busy for 5 cycles. Lane 0 first word = 32'h00042021, second = xs(32'h00042021). Seeded s[1] = 32'h6C078966 (probe lane state), so lane 1 first word = xs(32'h6C078966).
- Auto-seed: AUTO_SEED=1, rst released with seed_start=0 → seeding from 5489. The stream matches the reference model with s[0]=5489, and tvalid rises after LANES+1 cycles.
- Backpressure: tready toggled pseudo-randomly over 1000 words → tdata/tlast stable while stalled. The accepted sequence equals the reference model with no skips or duplicates.
- Burst: burst_len=10000 with tready=1 → exactly 10000 beats, tlast only on beat 10000, then tvalid=0, busy=0, and the FSM holds in DONE. burst_len=1 → a single beat with tlast.
- Reseed mid-stream: seed_start asserted while tvalid & !tready → tvalid drops the next cycle. A new stream from the new seed begins LANES+1 cycles after seed_start falls, with the counter restarted.
- Reset mid-SEED: rst asserted during cycle 2 of SEED → all outputs 0 the next cycle. After release, the AUTO_SEED=1 path restarts from DEFAULT_SEED.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared definitions for the multi-lane xorshift32 AXI-Stream generator.
// Holds the controller state encoding, the MT19937 seeding constants,
// the xorshift32 shift amounts and the pure xorshift32 step function.
package prng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } prng_state_e;

    localparam logic [31:0] MT_INIT_MULT  = 32'd1812433253;
    localparam int          MT_INIT_SHIFT = 30;

    localparam int XS_SH_A = 13;
    localparam int XS_SH_B = 17;
    localparam int XS_SH_C = 5;

    // One xorshift32 step; all shifts stay within 32 bits.
    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] v;
        v = x ^ (x << XS_SH_A);
        v = v ^ (v >> XS_SH_B);
        v = v ^ (v << XS_SH_C);
        return v;
    endfunction

endpackage

// File: rtl/xorshift32_lane.sv
// Single xorshift32 generator lane.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (state -> 0)
//   i_load      : load i_load_val into the state (has priority over advance)
//   i_load_val  : seed value for this lane
//   i_adv       : advance the state by one xorshift32 step
//   o_next      : xorshift32 of the current state (the value an advance stores)
module xorshift32_lane
    import prng_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_adv,
    output logic [31:0] o_next
);

    logic [31:0] r_state;

    assign o_next = xs32(r_state);

    // Lane state register: load wins over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 32'd0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_adv) begin
            r_state <= o_next;
        end
    end

endmodule

// File: rtl/axis_prng_multi.sv
// Multi-lane xorshift32 random generator with an AXI-Stream master output.
// Every lane is seeded from one 32-bit seed with the MT19937 init recurrence,
// computed one lane per cycle through a single shared multiplier.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   seed_val, burst_len : captured while seed_start is high
//   seed_start          : level request to (re)seed; seeding starts after it falls
//   output_axis_*       : AXI-Stream master (tdata lane i = bits [32*i+31:32*i])
//   busy                : high while seeding lanes and priming the first word
module axis_prng_multi
    import prng_pkg::*;
#(
    parameter int          LANES        = 4,
    parameter bit          AUTO_SEED    = 1'b1,
    parameter logic [31:0] DEFAULT_SEED = 32'd5489,
    parameter int          CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           seed_val,
    input  logic                  seed_start,
    input  logic [CNT_W-1:0]      burst_len,
    output logic [32*LANES-1:0]   output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  busy
);

    localparam int              IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    prng_state_e           r_state;
    prng_state_e           w_state_next;
    logic [31:0]           r_seed;
    logic [31:0]           r_acc;
    logic [CNT_W-1:0]      r_burst;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_auto_pend;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_busy;
    logic [32*LANES-1:0]   r_tdata;

    logic                  w_auto_go;
    logic                  w_seed_step;
    logic                  w_accept;
    logic                  w_adv;
    logic [31:0]           w_mt;
    logic [31:0]           w_lane_val;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [LANES-1:0]      w_load;
    logic [31:0]           w_lane_next [LANES];

    // In SEED, r_busy doubles as the "armed" flag: the first cycle after
    // seed_start falls only raises busy, the following LANES cycles load lanes.
    assign w_auto_go   = (r_state == ST_IDLE) && r_auto_pend && !seed_start;
    assign w_seed_step = (r_state == ST_SEED) && r_busy && !seed_start;
    assign w_accept    = (r_state == ST_RUN) && r_tvalid && output_axis_tready && !seed_start;
    assign w_adv       = ((r_state == ST_PRIME) && !seed_start) || w_accept;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // Shared MT19937 init multiplier; r_acc holds the raw (unpatched) s[i-1].
    assign w_mt       = (r_idx == IDX_W'(0)) ? r_seed
                      : MT_INIT_MULT * (r_acc ^ (r_acc >> MT_INIT_SHIFT)) + 32'(r_idx);
    assign w_lane_val = (w_mt == 32'd0) ? 32'd1 : w_mt;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_load[gi] = w_seed_step && (r_idx == IDX_W'(gi));

        xorshift32_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load[gi]),
            .i_load_val (w_lane_val),
            .i_adv      (w_adv),
            .o_next     (w_lane_next[gi])
        );
    end

    // Next-state logic; seed_start overrides every state.
    always_comb begin
        w_state_next = r_state;
        if (seed_start) begin
            w_state_next = ST_SEED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_auto_go) begin
                        w_state_next = ST_SEED;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_SEED: begin
                    if (w_seed_step && (r_idx == LAST_IDX)) begin
                        w_state_next = ST_PRIME;
                    end else begin
                        w_state_next = ST_SEED;
                    end
                end
                ST_PRIME: w_state_next = ST_RUN;
                ST_RUN: begin
                    if (w_accept && r_tlast) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register plus seeding, output word, counter and tlast registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_seed      <= 32'd0;
            r_acc       <= 32'd0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_auto_pend <= AUTO_SEED;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_tdata     <= '0;
        end else begin
            r_state <= w_state_next;
            if (seed_start) begin
                r_seed      <= seed_val;
                r_burst     <= burst_len;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_auto_pend <= 1'b0;
                r_tvalid    <= 1'b0;
                r_tlast     <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_auto_go) begin
                            r_seed      <= DEFAULT_SEED;
                            r_burst     <= '0;
                            r_cnt       <= '0;
                            r_idx       <= '0;
                            r_auto_pend <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                    ST_SEED: begin
                        if (!r_busy) begin
                            r_busy <= 1'b1;
                        end else begin
                            r_acc <= w_mt;
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    ST_PRIME: begin
                        for (int i = 0; i < LANES; i++) begin
                            r_tdata[32*i +: 32] <= w_lane_next[i];
                        end
                        r_tvalid <= 1'b1;
                        r_tlast  <= (r_burst == CNT_W'(1));
                        r_busy   <= 1'b0;
                    end
                    ST_RUN: begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc;
                            if (r_tlast) begin
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                            end else begin
                                for (int i = 0; i < LANES; i++) begin
                                    r_tdata[32*i +: 32] <= w_lane_next[i];
                                end
                                // tlast marks the word whose acceptance makes cnt == burst.
                                r_tlast <= (r_burst != '0) && (w_cnt_inc == r_burst - CNT_W'(1));
                            end
                        end
                    end
                    ST_DONE: r_busy <= 1'b0;
                    default: r_busy <= 1'b0;
                endcase
            end
        end
    end

    assign output_axis_tdata  = r_tdata;
    assign output_axis_tvalid = r_tvalid;
    assign output_axis_tlast  = r_tlast;
    assign busy               = r_busy;

endmodule

// File: tb/tb_axis_prng_multi.sv
// Self-checking bench for axis_prng_multi (LANES=4, AUTO_SEED=1).
// A behavioural model computes each lane's seeds from the MT19937 init
// recurrence and the word sequence by repeated xorshift32 steps; accepted
// words, tlast placement, latency and busy length are compared against it.
module tb_axis_prng_multi;

    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int W     = 32 * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      seed_val;
    logic             seed_start;
    logic [CNT_W-1:0] burst_len;
    logic [W-1:0]     tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_word [LANES];

    typedef struct {
        logic [31:0]      seed;
        logic [CNT_W-1:0] burst;
        int               nwords;
        bit               rnd;
        int               hold;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    axis_prng_multi #(
        .LANES        (LANES),
        .AUTO_SEED    (1'b1),
        .DEFAULT_SEED (32'd5489),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .seed_val           (seed_val),
        .seed_start         (seed_start),
        .burst_len          (burst_len),
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .busy               (busy)
    );

    function automatic logic [31:0] ref_xs(input logic [31:0] x);
        logic [31:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    // Model: seeds per lane, then the first word of each lane is xs(seed).
    task automatic model_seed(input logic [31:0] sd);
        logic [31:0] s;
        s = sd;
        for (int i = 0; i < LANES; i++) begin
            if (i > 0) s = 32'd1812433253 * (s ^ (s >> 30)) + 32'(i);
            m_word[i] = ref_xs((s == 32'd0) ? 32'd1 : s);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < LANES; i++) m_word[i] = ref_xs(m_word[i]);
    endtask

    function automatic logic [W-1:0] model_data();
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[32*i +: 32] = m_word[i];
        return v;
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called right after the releasing event (seed_start or rst driven low).
    // tvalid must rise LANES+1 cycles after the first low sample; busy lasts LANES+1.
    task automatic wait_valid(input string name);
        int k;
        int nbusy;
        k = 0;
        nbusy = 0;
        while (!tvalid && k < 50) begin
            cyc();
            k++;
            if (busy) nbusy++;
        end
        check_int({name, "_latency"}, k, LANES + 2);
        check_int({name, "_busy_len"}, nbusy, LANES + 1);
        check_bit({name, "_busy_after"}, busy, 1'b0);
    endtask

    // Consume n words; every valid cycle is checked against the model, so a
    // stalled word that changes is caught as well as skips and duplicates.
    task automatic run_words(input string name, input int n, input logic [CNT_W-1:0] bl, input bit rnd);
        int acc;
        int cycles;
        logic exp_last;
        acc = 0;
        cycles = 0;
        while (acc < n && cycles < n * 6 + 100) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid) begin
                exp_last = (bl != '0) && (acc + 1 == int'(bl));
                check_vec({name, "_tdata"}, tdata, model_data());
                check_bit({name, "_tlast"}, tlast, exp_last);
                if (tready) begin
                    model_step();
                    acc++;
                end
            end
            cyc();
            cycles++;
        end
        check_int({name, "_accepted"}, acc, n);
        if (bl != '0) begin
            for (int d = 0; d < 3; d++) begin
                check_bit({name, "_done_tvalid"}, tvalid, 1'b0);
                check_bit({name, "_done_busy"}, busy, 1'b0);
                check_bit({name, "_done_tlast"}, tlast, 1'b0);
                tready = 1'b1;
                cyc();
            end
        end
    endtask

    task automatic reseed(input string name, input logic [31:0] sd, input logic [CNT_W-1:0] bl, input int hold);
        seed_val   = sd;
        burst_len  = bl;
        seed_start = 1'b1;
        for (int h = 0; h < hold; h++) cyc();
        check_bit({name, "_hold_tvalid"}, tvalid, 1'b0);
        check_bit({name, "_hold_busy"}, busy, 1'b0);
        seed_start = 1'b0;
        seed_val   = $urandom;
        burst_len  = CNT_W'($urandom);
        model_seed(sd);
        wait_valid(name);
    endtask

    initial begin
        tbl[0] = '{32'hDEADBEEF, 16'd0,     1000,  1'b1, 1};
        tbl[1] = '{32'h12345678, 16'd1,     1,     1'b0, 2};
        tbl[2] = '{32'hCAFEBABE, 16'd10000, 10000, 1'b0, 1};
        tbl[3] = '{32'h00000000, 16'd5,     5,     1'b1, 3};
        tbl[4] = '{32'h0BADF00D, 16'd7,     7,     1'b1, 1};

        // Reset dominates a concurrent seed_start.
        rst        = 1'b1;
        seed_start = 1'b1;
        seed_val   = 32'hA5A5A5A5;
        burst_len  = 16'd3;
        tready     = 1'b1;
        cyc(); cyc(); cyc();
        check_vec("rst_tdata", tdata, W'(0));
        check_bit("rst_tvalid", tvalid, 1'b0);
        check_bit("rst_tlast", tlast, 1'b0);
        check_bit("rst_busy", busy, 1'b0);

        // Auto-seed from 5489 on reset release.
        seed_start = 1'b0;
        rst        = 1'b0;
        model_seed(32'd5489);
        wait_valid("auto");
        run_words("auto", 20, 16'd0, 1'b0);

        // Known-answer vectors for seed 1.
        tready = 1'b0;
        reseed("seed1", 32'd1, 16'd0, 1);
        check_vec("seed1_lane0_w0", W'(tdata[31:0]), W'(32'h00042021));
        check_vec("seed1_lane1_w0", W'(tdata[63:32]), W'(ref_xs(32'h6C078966)));
        tready = 1'b1;
        cyc();
        check_vec("seed1_lane0_w1", W'(tdata[31:0]), W'(ref_xs(32'h00042021)));
        model_step();
        run_words("seed1", 8, 16'd0, 1'b0);

        // Table of seeds, burst lengths and backpressure modes.
        for (int t = 0; t < 5; t++) begin
            reseed($sformatf("tbl%0d", t), tbl[t].seed, tbl[t].burst, tbl[t].hold);
            run_words($sformatf("tbl%0d", t), tbl[t].nwords, tbl[t].burst, tbl[t].rnd);
        end

        // Reseed while a transfer is stalled; the new burst restarts the counter.
        reseed("mid_a", 32'h13579BDF, 16'd50, 1);
        run_words("mid_a", 5, 16'd0, 1'b0);
        tready = 1'b0;
        cyc();
        check_bit("mid_stalled", tvalid, 1'b1);
        seed_start = 1'b1;
        seed_val   = 32'h2468ACE0;
        burst_len  = 16'd3;
        cyc();
        check_bit("mid_abort_tvalid", tvalid, 1'b0);
        check_bit("mid_abort_tlast", tlast, 1'b0);
        cyc();
        seed_start = 1'b0;
        seed_val   = $urandom;
        model_seed(32'h2468ACE0);
        wait_valid("mid_b");
        run_words("mid_b", 3, 16'd3, 1'b1);

        // Reset in the second SEED cycle, then auto-seed again from 5489.
        reseed("pre_rst", 32'h00C0FFEE, 16'd0, 1);
        run_words("pre_rst", 4, 16'd0, 1'b0);
        seed_val   = 32'h77777777;
        burst_len  = 16'd0;
        seed_start = 1'b1;
        cyc();
        seed_start = 1'b0;
        cyc();
        cyc();
        check_bit("seed_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        cyc();
        check_vec("midseed_rst_tdata", tdata, W'(0));
        check_bit("midseed_rst_tvalid", tvalid, 1'b0);
        check_bit("midseed_rst_tlast", tlast, 1'b0);
        check_bit("midseed_rst_busy", busy, 1'b0);
        rst = 1'b0;
        model_seed(32'd5489);
        wait_valid("auto2");
        run_words("auto2", 30, 16'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
